// File: rtl/vector_lsu_strided_pkg.sv
// vlsu_pkg: shared types and helpers for the strided vector load/store unit.
//   state_e      FSM state encoding (IDLE, XFER, WB, DONE)
//   ELEM_W       element-index width for the default lane count
//   VREG_W       vector-register-index width for the default register count
//   clamp_vl()   element count = min(vl, lanes), unsigned compare on full vl
package vlsu_pkg;

  localparam int NUM_LANES_DFLT = 8;
  localparam int NUM_VREGS_DFLT = 8;
  localparam int ELEM_W         = $clog2(NUM_LANES_DFLT);
  localparam int VREG_W         = $clog2(NUM_VREGS_DFLT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  // vl arrives zero-extended to 64 bits so huge requests compare correctly.
  function automatic int unsigned clamp_vl(input logic [63:0] vl,
                                           input int unsigned lanes);
    if (vl < 64'(lanes))
      return vl[31:0];
    else
      return lanes;
  endfunction

endpackage

// File: rtl/vector_lsu_strided_addr_gen.sv
// vlsu_addr_gen: element address / index generator.
//   load       latch base address, stride and last index; idx restarts at 0
//   advance    addr += stride (two's-complement wrap), idx += 1
//   addr, idx  current element address and index
//   last       idx is the final element of the transfer
module vlsu_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int LANE_W = 3
) (
  input  logic                     clk_V,
  input  logic                     reset,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic signed [ADDR_W-1:0] stride,
  input  logic [LANE_W-1:0]        n_last,
  input  logic                     advance,
  output logic [ADDR_W-1:0]        addr,
  output logic [LANE_W-1:0]        idx,
  output logic                     last
);

  logic signed [ADDR_W-1:0] stride_q;
  logic [LANE_W-1:0]        n_last_q;

  always_ff @(posedge clk_V or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      idx      <= '0;
      stride_q <= '0;
      n_last_q <= '0;
    end else if (load) begin
      addr     <= base_addr;
      idx      <= '0;
      stride_q <= stride;
      n_last_q <= n_last;
    end else if (advance) begin
      // Unsigned add of the two's-complement stride gives the signed step mod 2^ADDR_W.
      addr <= addr + $unsigned(stride_q);
      idx  <= idx + LANE_W'(1);
    end
  end

  assign last = (idx == n_last_q);

endmodule

// File: rtl/vector_lsu_strided.sv
// vector_lsu_strided: strided vector load/store unit.
// Moves min(vl, NUM_LANES) elements between the vector register file and data
// memory, one element per granted request, with a signed byte stride.
//   start/is_store/vl/base_addr/stride/vreg  launch command (sampled with start)
//   busy, done                               operation status / completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata        memory request, held until mem_gnt
//   mem_gnt, mem_rdata                       grant and load data (same cycle)
//   vrf_we/vrf_reg/vrf_elem/vrf_wdata        VRF write port (loads, one cycle after grant)
//   vrf_rdata                                combinational VRF read (stores)
// Optional build macro VLSU_MASK_EN adds a per-element mask input; masked
// elements spend one cycle with no request and no VRF write.
module vector_lsu_strided
  import vlsu_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_VREGS = 8
) (
  input  logic                         clk_V,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         is_store,
  input  logic [DATA_W-1:0]            vl,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic signed [ADDR_W-1:0]     stride,
  input  logic [$clog2(NUM_VREGS)-1:0] vreg,
`ifdef VLSU_MASK_EN
  input  logic [NUM_LANES-1:0]         mask,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_gnt,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         vrf_we,
  output logic [$clog2(NUM_VREGS)-1:0] vrf_reg,
  output logic [$clog2(NUM_LANES)-1:0] vrf_elem,
  output logic [DATA_W-1:0]            vrf_wdata,
  input  logic [DATA_W-1:0]            vrf_rdata
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int REG_W  = $clog2(NUM_VREGS);
  localparam int CNT_W  = LANE_W + 1;

  state_e              state, state_next;
  logic                launch, in_xfer, active, advance, grant, last;
  logic                is_store_q;
  logic [REG_W-1:0]    vreg_q;
  logic [CNT_W-1:0]    n_start;
  logic [LANE_W-1:0]   idx;
  logic [ADDR_W-1:0]   addr_q;
  logic                wb_vld_p1;
  logic [LANE_W-1:0]   wb_idx_p1;
  logic [DATA_W-1:0]   wb_data_p1;
`ifdef VLSU_MASK_EN
  logic [NUM_LANES-1:0] mask_q;
`endif

  assign n_start = CNT_W'(clamp_vl(64'(vl), NUM_LANES));
  assign launch  = (state == IDLE) && start;
  assign in_xfer = (state == XFER);

`ifdef VLSU_MASK_EN
  assign active = mask_q[idx];
`else
  assign active = 1'b1;
`endif

  // Masked elements advance unconditionally; active ones wait for the grant.
  assign advance = in_xfer && (active ? mem_gnt : 1'b1);
  assign grant   = in_xfer && active && mem_gnt;

  vlsu_addr_gen #(
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_addr_gen (
    .clk_V     (clk_V),
    .reset     (reset),
    .load      (launch),
    .base_addr (base_addr),
    .stride    (stride),
    .n_last    (LANE_W'(n_start - CNT_W'(1))),
    .advance   (advance),
    .addr      (addr_q),
    .idx       (idx),
    .last      (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (n_start == '0) ? DONE : XFER;
      XFER:    if (advance && last) state_next = is_store_q ? DONE : WB;
      WB:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = in_xfer || (state == WB);
    done      = (state == DONE);
    mem_req   = in_xfer && active;
    mem_we    = mem_req && is_store_q;
    mem_addr  = mem_req ? addr_q : '0;
    mem_wdata = mem_we ? vrf_rdata : '0;
    vrf_we    = wb_vld_p1;
    vrf_reg   = vreg_q;
    vrf_wdata = wb_data_p1;
    // Loads never read the VRF, so the element port can carry the write-back index.
    vrf_elem  = wb_vld_p1 ? wb_idx_p1 : (in_xfer ? idx : '0);
  end

  // Stage p0 -> p1: load data captured on grant, written back next cycle
  always_ff @(posedge clk_V or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      vreg_q     <= '0;
      wb_vld_p1  <= 1'b0;
      wb_idx_p1  <= '0;
      wb_data_p1 <= '0;
`ifdef VLSU_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state     <= state_next;
      wb_vld_p1 <= grant && !is_store_q;
      if (launch) begin
        is_store_q <= is_store;
        vreg_q     <= vreg;
`ifdef VLSU_MASK_EN
        mask_q     <= mask;
`endif
      end
      if (grant && !is_store_q) begin
        wb_idx_p1  <= idx;
        wb_data_p1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vector_lsu_strided.sv
// Self-checking bench for vector_lsu_strided. The bench acts as the VRF and as
// a memory whose read data is a fixed function of the address; expected
// request/write-back lists are derived from base + i*stride for i < min(vl,8).
// Build with VLSU_MASK_EN defined to also exercise the mask port.
module tb_vector_lsu_strided;

  localparam int NL = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NV = 8;

  logic                 clk_V = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 is_store = 1'b0;
  logic [DW-1:0]        vl = '0;
  logic [AW-1:0]        base_addr = '0;
  logic signed [AW-1:0] stride = '0;
  logic [2:0]           vreg = '0;
`ifdef VLSU_MASK_EN
  logic [NL-1:0]        mask = '0;
`endif
  logic                 busy, done, mem_req, mem_we, vrf_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata, mem_rdata, vrf_wdata, vrf_rdata;
  logic                 mem_gnt = 1'b0;
  logic [2:0]           vrf_reg, vrf_elem;

  logic [DW-1:0]        vrf_mem [NV][NL];
  int                   n_tests = 0;
  int                   n_fail  = 0;

  always #5 clk_V = ~clk_V;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  assign mem_rdata = mem_fn(mem_addr);
  assign vrf_rdata = vrf_mem[vrf_reg][vrf_elem];

  vector_lsu_strided dut (
    .clk_V     (clk_V),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .vl        (vl),
    .base_addr (base_addr),
    .stride    (stride),
    .vreg      (vreg),
`ifdef VLSU_MASK_EN
    .mask      (mask),
`endif
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .vrf_we    (vrf_we),
    .vrf_reg   (vrf_reg),
    .vrf_elem  (vrf_elem),
    .vrf_wdata (vrf_wdata),
    .vrf_rdata (vrf_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_mem_req"},   mem_req,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_vrf_we"},    vrf_we,    0);
    check({tag, "_vrf_reg"},   vrf_reg,   0);
    check({tag, "_vrf_elem"},  vrf_elem,  0);
    check({tag, "_vrf_wdata"}, vrf_wdata, 0);
  endtask

  // gmode: 0 = grant always, 1 = grant every other cycle, 2 = random grant
  task automatic run_op(input logic st, input logic [31:0] vl_i, input logic [31:0] base_i,
                        input logic [31:0] stride_i, input logic [2:0] vr, input int gmode,
                        input logic [NL-1:0] msk_i);
    logic [NL-1:0] msk;
    int            n, cyc, done_cyc;
    bit            seen_done, stall, g;
    logic [AW-1:0] prev_addr, a;
    logic [AW-1:0] exp_addr[$], got_addr[$];
    logic [DW-1:0] exp_wd[$], got_wd[$], exp_ld[$], got_ld[$];
    int            exp_el[$], got_el[$];

    msk = msk_i;
`ifndef VLSU_MASK_EN
    msk = '1;
`endif
    n = (vl_i < 32'(NL)) ? int'(vl_i) : NL;
    for (int i = 0; i < n; i++) begin
      if (msk[i]) begin
        a = base_i + stride_i * 32'(i);
        exp_addr.push_back(a);
        if (st) exp_wd.push_back(vrf_mem[vr][i]);
        else begin
          exp_el.push_back(i);
          exp_ld.push_back(mem_fn(a));
        end
      end
    end

    @(negedge clk_V);
    start = 1'b1; is_store = st; vl = vl_i; base_addr = base_i; stride = stride_i; vreg = vr;
`ifdef VLSU_MASK_EN
    mask = msk_i;
`endif
    @(posedge clk_V);
    #1;
    // Scramble the command inputs to show they were latched at start.
    start = 1'b0; is_store = 1'($urandom); vl = $urandom; base_addr = $urandom;
    stride = $urandom; vreg = 3'($urandom);

    seen_done = 0; stall = 0; done_cyc = -1; prev_addr = '0;
    for (cyc = 1; cyc <= 64 && !seen_done; cyc++) begin
      @(negedge clk_V);
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        check("busy_at_done", busy, 0);
      end else begin
        check("busy", busy, 1);
      end
      if (stall) begin
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, prev_addr);
      end
      if (mem_req) check("mem_we", mem_we, st);
      case (gmode)
        0:       g = 1'b1;
        1:       g = cyc[0];
        default: g = 1'($urandom);
      endcase
      mem_gnt = g;
      if (mem_req && g) begin
        got_addr.push_back(mem_addr);
        if (st) got_wd.push_back(mem_wdata);
      end
      stall     = mem_req && !g;
      prev_addr = mem_addr;
      if (vrf_we) begin
        got_el.push_back(int'(vrf_elem));
        got_ld.push_back(vrf_wdata);
        check("vrf_reg", vrf_reg, vr);
        vrf_mem[vrf_reg][vrf_elem] = vrf_wdata;
      end
    end
    mem_gnt = 1'b0;

    check("done_seen", seen_done, 1);
    if (gmode == 0) check("done_cycle", done_cyc, (n == 0) ? 1 : (st ? n + 1 : n + 2));
    check("req_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check("req_addr", got_addr[i], exp_addr[i]);
    for (int i = 0; i < exp_wd.size() && i < got_wd.size(); i++)
      check("store_data", got_wd[i], exp_wd[i]);
    check("wb_count", got_el.size(), exp_el.size());
    for (int i = 0; i < exp_el.size() && i < got_el.size(); i++) begin
      check("wb_elem", got_el[i], exp_el[i]);
      check("wb_data", got_ld[i], exp_ld[i]);
    end
    @(negedge clk_V);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int r = 0; r < NV; r++)
      for (int e = 0; e < NL; e++)
        vrf_mem[r][e] = $urandom;

    #12;
    check_zero("rst");
    @(negedge clk_V);
    reset = 1'b1;

    run_op(1'b0, 32'd8, 32'h100, 32'd4, 3'd2, 0, '1);                 // unit-stride load
    run_op(1'b1, 32'd4, 32'h40, 32'hFFFF_FFF8, 3'd5, 1, '1);          // negative stride, stalls
    run_op(1'b1, 32'd20, 32'h1000, 32'd16, 3'd1, 0, '1);              // clamp store
    run_op(1'b0, 32'd20, 32'h2000, 32'd8, 3'd4, 0, '1);               // clamp load
    run_op(1'b0, 32'hFFFF_FFFF, 32'h2400, 32'd4, 3'd3, 0, '1);        // clamp, huge vl
    run_op(1'b0, 32'd0, 32'h200, 32'd4, 3'd0, 0, '1);                 // zero-length load
    run_op(1'b1, 32'd0, 32'h200, 32'd4, 3'd0, 0, '1);                 // zero-length store
    run_op(1'b1, 32'd2, 32'hFFFF_FFFC, 32'd4, 3'd3, 0, '1);           // address wrap
    run_op(1'b1, 32'd1, 32'h80, 32'd4, 3'd7, 0, '1);                  // single element

    // Reset in the middle of a load after three grants.
    @(negedge clk_V);
    start = 1'b1; is_store = 1'b0; vl = 32'd8; base_addr = 32'h500; stride = 32'sd4; vreg = 3'd1;
`ifdef VLSU_MASK_EN
    mask = '1;
`endif
    mem_gnt = 1'b1;
    @(posedge clk_V);
    #1 start = 1'b0;
    repeat (3) @(posedge clk_V);
    @(negedge clk_V);
    check("busy_pre_rst", busy, 1);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (3) begin
      @(negedge clk_V);
      check("no_done_in_rst", done, 0);
    end
    mem_gnt = 1'b0;
    reset = 1'b1;
    run_op(1'b0, 32'd5, 32'h600, 32'd12, 3'd1, 0, '1);

`ifdef VLSU_MASK_EN
    run_op(1'b0, 32'd8, 32'h300, 32'd4, 3'd6, 0, 8'b1010_0101);
    run_op(1'b1, 32'd6, 32'h340, 32'd4, 3'd6, 0, 8'h00);
`endif

    for (int t = 0; t < 24; t++) begin
      logic [31:0] rv, rs;
      rv = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 10);
      rs = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 64)) - 32'd32) : $urandom;
      run_op(1'($urandom), rv, $urandom, rs, 3'($urandom), int'($urandom_range(0, 2)),
             8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
